// File: rtl/par_alu_reg_if.sv
// par_alu_reg_if: operand/function request and result/status bus of the register ALU
interface par_alu_reg_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0]   Data;
    logic [2:0]         Function;
    logic               Start;
    logic [2*WIDTH-1:0] ALUout;
    logic               Busy;
    logic               Done;
    modport master (output Data, Function, Start, input ALUout, Busy, Done);
    modport slave  (input Data, Function, Start, output ALUout, Busy, Done);
endinterface

// File: rtl/par_alu_reg.sv
// par_alu_reg: accumulator-style ALU (B = ALUout low half) with a WIDTH-cycle shift-add multiplier
module par_alu_reg #(
    parameter int WIDTH = 4
) (
    input  logic          Clock,
    input  logic          Reset_b,
    par_alu_reg_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, MUL} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] alu_q, alu_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   b, diff;
    assign b    = alu_q[WIDTH-1:0];
    assign diff = bus.Data - b;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        alu_d    = alu_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.Start) begin
                done_d = 1'b1;
                case (bus.Function)
                    3'b000: alu_d = (2*WIDTH)'(bus.Data) + (2*WIDTH)'(b);
                    3'b001: alu_d = {{WIDTH{diff[WIDTH-1]}}, diff};
                    3'b010: alu_d = {{WIDTH{bus.Data[WIDTH-1]}}, bus.Data};
                    3'b011: alu_d = (2*WIDTH)'(|{bus.Data, b});
                    3'b100: alu_d = (2*WIDTH)'(&{bus.Data, b});
                    3'b101: alu_d = {bus.Data, b};
                    3'b110: begin
                        done_d   = 1'b0;
                        state_d  = MUL;
                        mcand_d  = (2*WIDTH)'(bus.Data);
                        mplier_d = b;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end
                    default: alu_d = alu_q;
                endcase
            end
        end else begin
            // multiplier shifts right while the multiplicand shifts left, so bit 0 always selects
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                alu_d   = prod_d;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            alu_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            alu_q    <= alu_d;
            done_q   <= done_d;
        end
    end
    assign bus.ALUout = alu_q;
    assign bus.Busy   = (state_q == MUL);
    assign bus.Done   = done_q;
endmodule
